noc_packetizer: RTL
===================

NOC_PACKETIZER -- requirements
Module: noc_packetizer

Interface
REQ-001 SHALL have parameter PAYLOAD_DATA_WIDTH, default 512, payload bits per beat.
REQ-002 SHALL have parameter MESH_SIZE_X, default 65, mesh columns; DEST_ADDR_SIZE_X = clog2(MESH_SIZE_X).
REQ-003 SHALL have parameter MESH_SIZE_Y, default 65, mesh rows; DEST_ADDR_SIZE_Y = clog2(MESH_SIZE_Y); MESH_NODE_ID_WIDTH = X + Y width.
REQ-004 SHALL have parameter MAX_BEATS, default 255, largest packet in payload beats; BEAT_W = clog2(MAX_BEATS+1).
REQ-005 SHALL use a single clock and an asynchronous, active-low reset: core_clk input 1, all logic rising-edge; resetn input 1, active-low asynchronous reset.
REQ-006 req_valid input 1, packet request present.
REQ-007 req_ready output 1, request accepted when req_valid and req_ready are both high.
REQ-008 req_dest_col input DEST_ADDR_SIZE_X, destination x.
REQ-009 req_dest_row input DEST_ADDR_SIZE_Y, destination y.
REQ-010 req_src_id input MESH_NODE_ID_WIDTH, source node id, {col,row}.
REQ-011 req_beats input BEAT_W, payload beats in packet.
REQ-012 data_valid input 1 and data_payload input PAYLOAD_DATA_WIDTH: one payload beat.
REQ-013 data_ready output 1, beat consumed when data_valid and data_ready are both high.
REQ-014 flit_valid output 1 and flit_out output 2+FLIT_DATA_SIZE, flit in noc_pkg flit_novc_t layout.
REQ-015 flit_ready input 1, downstream router accepts flit_out.
REQ-016 busy output 1, high in any state other than IDLE.

Function
REQ-017 Flit layout, MSB first: flit_label[1:0] (HEAD=0, BODY=1, TAIL=2, HEADTAIL=3), then data.
REQ-018 HEAD/HEADTAIL data = {x_dest, y_dest, head_pl}, where head_pl = {req_src_id, beat0 payload} and head_pl is MESH_NODE_ID_WIDTH+PAYLOAD_DATA_WIDTH bits wide.
REQ-019 BODY/TAIL data: bt_pl = payload in low PAYLOAD_DATA_WIDTH bits, upper bits zero.
REQ-020 FSM states: IDLE, HEAD, STREAM.
- IDLE: req_ready = 1; on accept, latch dest/src/beats and go to HEAD.
- HEAD: consumes beat 0 and emits HEAD (beats >= 2, then go to STREAM) or HEADTAIL (beats <= 1, then go to IDLE).
- STREAM: each beat emits BODY; the final beat emits TAIL and returns to IDLE.
REQ-021 req_beats = 0 SHALL emit a single HEADTAIL with zero payload, consume no data beat, and return to IDLE.
REQ-022 req_beats > MAX_BEATS is illegal; behaviour undefined, no check required.
REQ-023 The remaining-beat counter SHALL load req_beats-1 on accept and decrement on each beat consumed after beat 0; the last beat is detected when the counter reaches 1 in STREAM.
REQ-024 flit_out/flit_valid SHALL be registered; a beat accepted in cycle N appears as flit_valid in cycle N+1.
REQ-025 data_ready = (state is HEAD or STREAM) and (!flit_valid or flit_ready): the output register accepts a new flit only when it is empty or draining.
REQ-026 A zero-beat HEADTAIL SHALL load under the same output-register condition as REQ-025.
REQ-027 Sustained throughput SHALL be one flit per cycle while data_valid and flit_ready are held high.
REQ-028 flit_out SHALL hold stable while flit_valid is high and flit_ready is low.
REQ-029 flit_valid SHALL drop the cycle after the last flit is taken unless a new flit is loaded in that same cycle.
REQ-030 req_ready SHALL be 0 outside IDLE; the next request SHALL be accepted the cycle after TAIL/HEADTAIL is loaded, even while that flit is still pending.
REQ-031 Requests are never interleaved: all flits of packet k precede the HEAD of packet k+1.

Reset
REQ-032 resetn low SHALL asynchronously force: state IDLE, flit_valid 0, flit_out 0, counter 0, data_ready 0, busy 0, req_ready 0 while asserted.
REQ-033 Reset asserted mid-packet SHALL abandon the packet with no TAIL emitted; after release the block waits for a fresh request.
REQ-034 req_ready SHALL go to 1 in the first cycle after resetn deasserts.

Verification
REQ-035 req_beats=1, dest (3,5), src 0x0A2, data 0xAB..AB -> one HEADTAIL, x_dest=3, y_dest=5, head_pl top bits 0x0A2, low bits 0xAB..AB; busy then clears.
REQ-036 req_beats=4, flit_ready=1, data each cycle -> flits HEAD, BODY, BODY, TAIL on consecutive cycles; bt_pl upper bits zero.
REQ-037 req_beats=3, flit_ready held low 5 cycles after HEAD -> flit_out stable, data_ready=0, no beat lost; sequence completes after release.
REQ-038 req_beats=0 -> single HEADTAIL with zero payload, data_ready never asserted.
REQ-039 resetn pulsed low after BODY #2 of a 6-beat packet -> flit_valid=0 immediately; next 2-beat request yields a clean HEAD, TAIL.
REQ-040 Back-to-back requests (2 beats, then 1 beat) with req_valid held high -> HEAD, TAIL, HEADTAIL in order, second request accepted the cycle after TAIL loads.

Source files
------------

// File: rtl/noc_packetizer.sv
// Packetizer: turns a request plus a stream of payload beats into HEAD/BODY/TAIL
// (or a single HEADTAIL) flits through one registered output stage.
module noc_packetizer #(
   parameter  int PAYLOAD_DATA_WIDTH = 512,
   parameter  int MESH_SIZE_X        = 65,
   parameter  int MESH_SIZE_Y        = 65,
   parameter  int MAX_BEATS          = 255,
   localparam int DEST_ADDR_SIZE_X   = $clog2(MESH_SIZE_X),
   localparam int DEST_ADDR_SIZE_Y   = $clog2(MESH_SIZE_Y),
   localparam int MESH_NODE_ID_WIDTH = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y,
   localparam int BEAT_W             = $clog2(MAX_BEATS + 1),
   localparam int FLIT_DATA_SIZE     = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y
                                       + MESH_NODE_ID_WIDTH + PAYLOAD_DATA_WIDTH
) (
   input  logic                          core_clk,
   input  logic                          resetn,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [DEST_ADDR_SIZE_X-1:0]   req_dest_col,
   input  logic [DEST_ADDR_SIZE_Y-1:0]   req_dest_row,
   input  logic [MESH_NODE_ID_WIDTH-1:0] req_src_id,
   input  logic [BEAT_W-1:0]             req_beats,
   input  logic                          data_valid,
   input  logic [PAYLOAD_DATA_WIDTH-1:0] data_payload,
   output logic                          data_ready,
   output logic                          flit_valid,
   output logic [FLIT_DATA_SIZE+1:0]     flit_out,
   input  logic                          flit_ready,
   output logic                          busy
);

   typedef enum logic [1:0] {IDLE, HEAD, STREAM} state_t;
   typedef enum logic [1:0] {
      LBL_HEAD     = 2'd0,
      LBL_BODY     = 2'd1,
      LBL_TAIL     = 2'd2,
      LBL_HEADTAIL = 2'd3
   } flit_label_t;

   state_t                          state, state_nxt;
   logic [DEST_ADDR_SIZE_X-1:0]     dest_col_q;
   logic [DEST_ADDR_SIZE_Y-1:0]     dest_row_q;
   logic [MESH_NODE_ID_WIDTH-1:0]   src_q;
   logic [BEAT_W-1:0]               beats_q;
   logic [BEAT_W-1:0]               cnt_q;

   logic                            out_free;
   logic                            req_fire;
   logic                            data_fire;
   logic                            zero_pkt;
   logic                            single_pkt;
   logic                            last_stream;
   logic                            load_zero;
   logic                            load_flit;
   flit_label_t                     flit_lbl;
   logic [PAYLOAD_DATA_WIDTH-1:0]   head_payload;
   logic [FLIT_DATA_SIZE+1:0]       flit_nxt;

   assign out_free    = !flit_valid || flit_ready;
   assign req_fire    = req_valid && req_ready;
   assign data_fire   = data_valid && data_ready;
   assign zero_pkt    = (beats_q == '0);
   assign single_pkt  = (beats_q <= BEAT_W'(1));
   assign last_stream = (cnt_q == BEAT_W'(1));
   // A zero-beat packet has no data handshake; it loads on output-register space alone.
   assign load_zero   = (state == HEAD) && zero_pkt && out_free;
   assign load_flit   = data_fire || load_zero;

   always_ff @(posedge core_clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req_fire) state_nxt = HEAD;
         HEAD: begin
            if (load_zero)      state_nxt = IDLE;
            else if (data_fire) state_nxt = single_pkt ? IDLE : STREAM;
         end
         STREAM:  if (data_fire && last_stream) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE) && resetn;
      busy       = (state != IDLE);
      data_ready = 1'b0;
      flit_lbl   = LBL_BODY;
      unique case (state)
         HEAD: begin
            data_ready = out_free && !zero_pkt;
            flit_lbl   = single_pkt ? LBL_HEADTAIL : LBL_HEAD;
         end
         STREAM: begin
            data_ready = out_free;
            flit_lbl   = last_stream ? LBL_TAIL : LBL_BODY;
         end
         default: ;
      endcase
   end

   assign head_payload = zero_pkt ? '0 : data_payload;
   assign flit_nxt     = (state == HEAD)
                         ? {flit_lbl, dest_col_q, dest_row_q, src_q, head_payload}
                         : {flit_lbl, FLIT_DATA_SIZE'(data_payload)};

   always_ff @(posedge core_clk or negedge resetn) begin
      if (!resetn) begin
         dest_col_q <= '0;
         dest_row_q <= '0;
         src_q      <= '0;
         beats_q    <= '0;
         cnt_q      <= '0;
         flit_valid <= 1'b0;
         flit_out   <= '0;
      end else begin
         if (req_fire) begin
            dest_col_q <= req_dest_col;
            dest_row_q <= req_dest_row;
            src_q      <= req_src_id;
            beats_q    <= req_beats;
            cnt_q      <= req_beats - BEAT_W'(1);
         end else if ((state == STREAM) && data_fire) begin
            cnt_q <= cnt_q - BEAT_W'(1);
         end
         if (load_flit) begin
            flit_out   <= flit_nxt;
            flit_valid <= 1'b1;
         end else if (flit_ready) begin
            flit_valid <= 1'b0;
         end
      end
   end

endmodule
